// File: rtl/cnna_udiv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cnna_udiv_pkg : shared widths, saturation value and FSM states for the divider
// Rev 1.0
// ----------------------------------------------------------------------------
package cnna_udiv_pkg;

  localparam int DIVIDEND_W = 18;
  localparam int DIVISOR_W  = 5;
  localparam int QUOT_W     = 13;
  localparam int CNT_W      = 5;

  localparam logic [QUOT_W-1:0] QUOT_SAT = 13'h1FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cnna_udiv_18ns_5ns_13_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cnna_udiv_18ns_5ns_13_step : one combinational restoring-division step
// Rev 1.0
// ----------------------------------------------------------------------------
module cnna_udiv_18ns_5ns_13_step
  import cnna_udiv_pkg::*;
(
  input  logic [DIVISOR_W:0]   pr_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   pr_o,
  output logic                 qbit_o
);

  logic [DIVISOR_W:0] w_shift;

  always_comb begin
    w_shift = {pr_i[DIVISOR_W-1:0], bit_i};
    pr_o    = w_shift;
    qbit_o  = 1'b0;
    // A set pr MSB means the shifted value already exceeds any divisor.
    if (pr_i[DIVISOR_W] || (w_shift >= {1'b0, divisor_i})) begin
      pr_o   = w_shift - {1'b0, divisor_i};
      qbit_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnna_udiv_18ns_5ns_13_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cnna_udiv_18ns_5ns_13_seq : sequential 18/5 unsigned restoring divider,
// saturating 13-bit quotient, valid/ready on both sides.   Rev 1.0
// ----------------------------------------------------------------------------
module cnna_udiv_18ns_5ns_13_seq
  import cnna_udiv_pkg::*;
#(
  parameter int din0_WIDTH = DIVIDEND_W,
  parameter int din1_WIDTH = DIVISOR_W,
  parameter int dout_WIDTH = QUOT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [dout_WIDTH-1:0] dout_quot,
  output logic [din1_WIDTH-1:0] dout_rem,
  output logic                  dout_ovf,
  output logic                  dout_dz,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_e state_q, state_d;

  logic [din0_WIDTH-1:0] q_q;
  logic [din1_WIDTH-1:0] div_q;
  logic [din1_WIDTH:0]   pr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [dout_WIDTH-1:0] quot_q;
  logic [din1_WIDTH-1:0] rem_q;
  logic                  ovf_q;
  logic                  dz_q;

  logic [din1_WIDTH:0]   w_pr_nxt;
  logic                  w_qbit;
  logic [din0_WIDTH-1:0] w_q_nxt;
  logic                  w_dz;
  logic                  w_ovf;
  logic                  w_last;
  logic                  w_accept;

  cnna_udiv_18ns_5ns_13_step u_step (
    .pr_i      (pr_q),
    .bit_i     (q_q[din0_WIDTH-1]),
    .divisor_i (div_q),
    .pr_o      (w_pr_nxt),
    .qbit_o    (w_qbit)
  );

  assign w_q_nxt  = {q_q[din0_WIDTH-2:0], w_qbit};
  assign w_dz     = (div_q == '0);
  assign w_ovf    = ~w_dz & (|w_q_nxt[din0_WIDTH-1:dout_WIDTH]);
  assign w_last   = (cnt_q == CNT_W'(din0_WIDTH - 1));
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_accept)  state_d = CALC;
      CALC:    if (w_last)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) & ~ap_rst;
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      q_q    <= '0;
      div_q  <= '0;
      pr_q   <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      ovf_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            q_q   <= din0;
            div_q <= din1;
            pr_q  <= '0;
            cnt_q <= '0;
          end
        end
        CALC: begin
          q_q   <= w_q_nxt;
          pr_q  <= w_pr_nxt;
          cnt_q <= cnt_q + 1'b1;
          // Result registers capture the final step directly.
          if (w_last) begin
            dz_q   <= w_dz;
            ovf_q  <= w_ovf;
            quot_q <= (w_dz | w_ovf) ? QUOT_SAT : w_q_nxt[dout_WIDTH-1:0];
            rem_q  <= w_dz ? '0 : w_pr_nxt[din1_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign dout_quot = quot_q;
  assign dout_rem  = rem_q;
  assign dout_ovf  = ovf_q;
  assign dout_dz   = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_cnna_udiv_18ns_5ns_13_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cnna_udiv_18ns_5ns_13_seq : scoreboard bench for the sequential divider
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cnna_udiv_18ns_5ns_13_seq;

  logic        clk = 1'b0;
  logic        ap_rst;
  logic [17:0] din0;
  logic [4:0]  din1;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] dout_quot;
  logic [4:0]  dout_rem;
  logic        dout_ovf;
  logic        dout_dz;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  cnna_udiv_18ns_5ns_13_seq dut (
    .ap_clk    (clk),
    .ap_rst    (ap_rst),
    .din0      (din0),
    .din1      (din1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout_quot (dout_quot),
    .dout_rem  (dout_rem),
    .dout_ovf  (dout_ovf),
    .dout_dz   (dout_dz),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [12:0] quot;
    logic [4:0]  rem;
    logic        ovf;
    logic        dz;
    time         t_acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned a, input int unsigned b, input time t);
    exp_t        e;
    int unsigned qt;
    e.t_acc = t;
    if (b == 0) begin
      e.quot = 13'h1FFF; e.rem = 5'd0; e.dz = 1'b1; e.ovf = 1'b0;
    end else begin
      qt     = a / b;
      e.dz   = 1'b0;
      e.ovf  = (qt > 8191);
      e.quot = e.ovf ? 13'h1FFF : qt[12:0];
      e.rem  = 5'(a % b);
    end
    return e;
  endfunction

  // Drives at a negedge, waits for in_ready, records the accept edge.
  task automatic send(input int unsigned a, input int unsigned b);
    int n;
    din0 = 18'(a); din1 = 5'(b); in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    sb.push_back(model(a, b, $time));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // Output monitor: latency on the rising edge of out_valid, data on handshake.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!ap_rst) begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
        else chk("latency", 32'(($time - sb[0].t_acc) / 10), 32'd18);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("quot", 32'(dout_quot), 32'(e.quot));
        chk("rem",  32'(dout_rem),  32'(e.rem));
        chk("ovf",  32'(dout_ovf),  32'(e.ovf));
        chk("dz",   32'(dout_dz),   32'(e.dz));
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] hq;
    logic [4:0]  hr;
    logic [1:0]  hf;
    int          n;

    ap_rst = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_quot",      32'(dout_quot), 32'd0);
    chk("rst_rem",       32'(dout_rem),  32'd0);
    chk("rst_flags",     32'({dout_ovf, dout_dz}), 32'd0);
    ap_rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    send(20978, 17);  drain();
    send(100000, 13); drain();
    send(500, 0);     drain();

    // Backpressure with a second operand pair waiting during DONE.
    out_ready = 1'b0;
    send(262143, 31);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    chk("bp_valid", 32'(out_valid), 32'd1);
    hq = dout_quot; hr = dout_rem; hf = {dout_ovf, dout_dz};
    din0 = 18'd1000; din1 = 5'd7; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
      chk("bp_hold_q",   32'(dout_quot), 32'(hq));
      chk("bp_hold_r",   32'(dout_rem),  32'(hr));
      chk("bp_hold_f",   32'({dout_ovf, dout_dz}), 32'(hf));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle_ready", 32'(in_ready),  32'd1);
    chk("b2b_valid_low",  32'(out_valid), 32'd0);
    @(posedge clk);
    sb.push_back(model(1000, 7, $time));
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_busy", 32'(in_ready), 32'd0);
    drain();

    for (int i = 0; i < 6; i++) begin
      send($urandom_range(0, 262143), $urandom_range(0, 31));
      drain();
    end

    // Reset while iteration 9 would be computed.
    send(131071, 3);
    repeat (8) @(negedge clk);
    ap_rst = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready),  32'd0);
    chk("midrst_quot",  32'(dout_quot), 32'd0);
    chk("midrst_rem",   32'(dout_rem),  32'd0);
    chk("midrst_flags", 32'({dout_ovf, dout_dz}), 32'd0);
    ap_rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", 32'(in_ready), 32'd1);
    repeat (30) @(negedge clk);
    chk("midrst_no_stale", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cnna_udiv_18ns_5ns_13_seq.md
Name: cnna_udiv_18ns_5ns_13_seq

Overview:
- Sequential unsigned restoring divider. It is the inverse of the 13ns x 5ns -> 18 multiplier path in the CNN accelerator datapath.
- Takes an 18-bit dividend and a 5-bit divisor, and returns a 13-bit quotient, a 5-bit remainder and status flags.
- Used to recover per-channel counts and indices from flattened 18-bit addresses and products.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- din0_WIDTH, 18, dividend width; also the iteration count.
- din1_WIDTH, 5, divisor width; also the remainder width.
- dout_WIDTH, 13, output quotient width; the quotient saturates to this width.

Ports:
- ap_clk  in  1  sole clock; all state updates on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- din0  in  18  dividend, unsigned.
- din1  in  5  divisor, unsigned.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dout_quot  out  13  quotient, saturated.
- dout_rem  out  5  remainder.
- dout_ovf  out  1  true quotient exceeds 2^13-1.
- dout_dz  out  1  divisor was zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.

Behaviour:
- Clock and reset: one clock, ap_clk. ap_rst is synchronous and active-high.
- Reset, including mid-operation:
  - state=IDLE; out_valid=0; in_ready=0 during reset, then 1 from the first cycle after ap_rst deasserts.
  - dout_quot, dout_rem, dout_ovf and dout_dz all 0.
  - Any operation in flight is discarded with no output.
- States: IDLE, CALC, DONE.
  - in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On the edge where in_valid & in_ready: latch din0 into an 18-bit shift/quotient register, latch din1, clear the 6-bit partial remainder and the count, go to CALC.
  - Operands are sampled only on that edge.
- CALC, one quotient bit per edge, MSB first:
  - pr' = {pr[4:0], q[17]}.
  - If pr' >= {1'b0, divisor}: pr = pr' - divisor and shift 1 into q LSB. Otherwise pr = pr' and shift 0 into q LSB.
  - count++. The partial remainder is din1_WIDTH+1 bits wide so the compare never truncates.
- CALC -> DONE on the edge that performs iteration 18 (count==17).
- Output registers load on the CALC -> DONE edge:
  - dout_dz = (divisor==0).
  - dout_ovf = ~dout_dz & (q[17:13] != 0).
  - dout_quot = (dz | ovf) ? 13'h1FFF : q[12:0].
  - dout_rem = dz ? 0 : pr[4:0]. The remainder is exact even when ovf=1.
- Latency: if operands are accepted at edge k, out_valid is seen high after edge k+18. Latency is fixed for all operands, including divisor 0.
- DONE:
  - Outputs hold stable while out_ready=0, for any number of cycles.
  - in_valid is ignored (in_ready=0).
  - On an edge with out_ready=1: go to IDLE and clear out_valid. Data outputs keep their last values.
- Throughput: at most one operation per 20 cycles (accept, 18 CALC, DONE). A new input is accepted no earlier than the edge after the result handshake.
- Simultaneous ap_rst with any handshake: reset wins.

Decomposition:
- Package cnna_udiv_pkg:
  - State enum {IDLE, CALC, DONE}.
  - Localparams DIVIDEND_W=18, DIVISOR_W=5, QUOT_W=13, CNT_W=5, QUOT_SAT=13'h1FFF.
- Sub-module cnna_udiv_18ns_5ns_13_step: a purely combinational single restoring step.
  - Inputs: pr (6 bits), next dividend bit, divisor.
  - Outputs: new pr and the quotient bit.
  - Instantiated once; the top holds the FSM, counter and registers.

Test Plan:
- Exact division: din0=20978, din1=17 -> quot=1234, rem=0, ovf=0, dz=0; out_valid exactly 18 edges after accept.
- Normal division: din0=100000, din1=13 -> quot=7692, rem=4, ovf=0, dz=0.
- Overflow: din0=262143, din1=31 (true quotient 8456) -> quot=0x1FFF, rem=7, ovf=1, dz=0.
- Divide by zero: din0=500, din1=0 -> quot=0x1FFF, rem=0, dz=1, ovf=0; same 18-edge latency.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout.
  - Present a second operand pair (1000/7) during DONE -> not accepted until the edge after the result handshake; then quot=142, rem=6.
- Reset mid-CALC: assert ap_rst at iteration 9 -> next cycle out_valid=0 and all outputs 0; in_ready=1 after release; no stale result ever appears.
